// File: rtl/time_sync_pkg.sv
// Shared types and sizing helpers for the network-time synchronisation controller.
package time_sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SET,
        ST_FAIL
    } state_e;

    // Attempt index needs one bit beyond what MAX_RETRY strictly requires.
    function automatic int attempt_width(input int max_retry);
        return $clog2(max_retry + 1) + 1;
    endfunction

    // Width of a counter that must hold values 0..terminal.
    function automatic int count_width(input int terminal);
        return (terminal < 1) ? 1 : $clog2(terminal + 1);
    endfunction

    localparam int DEF_ATTEMPT_W = attempt_width(3);
    localparam int DEF_TIMEOUT_W = count_width(250_000_000 - 1);

endpackage

// File: rtl/sync_timer.sv
// Clearable up-counter; hit_o flags the terminal count and a step taken on
// the terminal count wraps back to zero.
module sync_timer #(
    parameter int          W        = 8,
    parameter int unsigned TERMINAL = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic step_i,
    output logic hit_o
);

    localparam logic [W-1:0] TERM = W'(TERMINAL);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign hit_o = (count_q == TERM);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (step_i) begin
            count_d = hit_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/time_sync_ctrl.sv
// Network-time sync controller: starts fetches on key press or periodic auto-resync,
// bounds each attempt with a timeout, retries, then loads the clock core or reports failure.
module time_sync_ctrl
    import time_sync_pkg::*;
#(
    parameter int TIME_W      = 32,
    parameter int OUT_W       = 64,
    parameter int TIMEOUT_CYC = 250_000_000,
    parameter int MAX_RETRY   = 3,
    parameter int AUTO_PERIOD = 3600
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                manual_btn,
    input  logic                                tick_1hz,
    input  logic                                fetch_done,
    input  logic [TIME_W-1:0]                   fetch_time,
    output logic                                req_en,
    output logic                                set_valid,
    output logic [OUT_W-1:0]                    set_time,
    output logic                                busy,
    output logic                                fail,
    output logic [attempt_width(MAX_RETRY)-1:0] attempt
);

    localparam int AW        = attempt_width(MAX_RETRY);
    localparam int TO_W      = count_width(TIMEOUT_CYC - 1);
    localparam bit AUTO_EN   = (AUTO_PERIOD != 0);
    localparam int AUTO_TERM = AUTO_EN ? AUTO_PERIOD - 1 : 0;
    localparam int AUTO_W    = count_width(AUTO_TERM);
    localparam logic [AW-1:0] MAX_A = AW'(MAX_RETRY);

    state_e            state_q, state_d;
    logic              btn_q;
    logic              auto_pend_q, auto_pend_d;
    logic [AW-1:0]     attempt_q, attempt_d;
    logic [OUT_W-1:0]  set_time_q, set_time_d;
    logic              req_en_q, set_valid_q, busy_q, fail_q;

    logic press;
    logic in_wait;
    logic to_hit;
    logic auto_hit;
    logic auto_fire;
    logic auto_clr;
    logic start_req;

    assign press   = manual_btn & ~btn_q;
    assign in_wait = (state_q == ST_WAIT);
    assign auto_clr = ~AUTO_EN;

    sync_timer #(
        .W        (TO_W),
        .TERMINAL (TIMEOUT_CYC - 1)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (~in_wait),
        .step_i  (in_wait),
        .hit_o   (to_hit)
    );

    // Terminal is one below the period so the tick completing the period fires directly.
    sync_timer #(
        .W        (AUTO_W),
        .TERMINAL (AUTO_TERM)
    ) u_auto (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (auto_clr),
        .step_i  (tick_1hz),
        .hit_o   (auto_hit)
    );

    assign auto_fire = AUTO_EN & tick_1hz & auto_hit;
    assign start_req = (state_q == ST_IDLE) & (press | auto_pend_q | auto_fire);

    always_comb begin
        state_d     = state_q;
        attempt_d   = attempt_q;
        set_time_d  = set_time_q;
        auto_pend_d = (auto_pend_q | auto_fire) & ~start_req;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d   = ST_REQ;
                    attempt_d = '0;
                end
            end
            ST_REQ: state_d = ST_WAIT;
            ST_WAIT: begin
                if (fetch_done) begin
                    state_d    = ST_SET;
                    set_time_d = OUT_W'(fetch_time);
                end else if (press) begin
                    state_d = ST_IDLE;
                end else if (to_hit) begin
                    if (attempt_q == MAX_A) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d   = ST_REQ;
                        attempt_d = attempt_q + AW'(1);
                    end
                end
            end
            ST_SET:  state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            btn_q       <= 1'b0;
            auto_pend_q <= 1'b0;
            attempt_q   <= '0;
            set_time_q  <= '0;
            req_en_q    <= 1'b0;
            set_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_q       <= manual_btn;
            auto_pend_q <= auto_pend_d;
            attempt_q   <= attempt_d;
            set_time_q  <= set_time_d;
            req_en_q    <= (state_d == ST_REQ);
            set_valid_q <= (state_d == ST_SET);
            busy_q      <= (state_d == ST_REQ) || (state_d == ST_WAIT);
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    assign req_en    = req_en_q;
    assign set_valid = set_valid_q;
    assign set_time  = set_time_q;
    assign busy      = busy_q;
    assign fail      = fail_q;
    assign attempt   = attempt_q;

endmodule

// File: tb/tb_time_sync_ctrl.sv
// Scoreboard bench for time_sync_ctrl with TIMEOUT_CYC=20, MAX_RETRY=2, AUTO_PERIOD=5.
module tb_time_sync_ctrl;

    localparam int K_REQ  = 1;
    localparam int K_SET  = 2;
    localparam int K_FAIL = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [63:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        manual_btn = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        fetch_done = 1'b0;
    logic [31:0] fetch_time = '0;
    logic        req_en;
    logic        set_valid;
    logic [63:0] set_time;
    logic        busy;
    logic        fail;
    logic [2:0]  attempt;

    int  cyc = 0;
    int  n_total = 0;
    int  n_bad = 0;
    ev_t sb[$];

    time_sync_ctrl #(
        .TIME_W      (32),
        .OUT_W       (64),
        .TIMEOUT_CYC (20),
        .MAX_RETRY   (2),
        .AUTO_PERIOD (5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .manual_btn (manual_btn),
        .tick_1hz   (tick_1hz),
        .fetch_done (fetch_done),
        .fetch_time (fetch_time),
        .req_en     (req_en),
        .set_valid  (set_valid),
        .set_time   (set_time),
        .busy       (busy),
        .fail       (fail),
        .attempt    (attempt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [63:0] d);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        ev_t         e;
        int          k;
        logic [63:0] d;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            check_eq("missed_event_cycle", 64'(cyc), 64'(e.cyc));
        end
        if (req_en || set_valid || fail) begin
            k = req_en ? K_REQ : (set_valid ? K_SET : K_FAIL);
            d = set_valid ? set_time : 64'(attempt);
            if (sb.size() == 0) begin
                check_eq("unexpected_event_kind", 64'(k), 64'(0));
            end else begin
                e = sb.pop_front();
                check_eq("event_kind", 64'(k), 64'(e.kind));
                check_eq("event_cycle", 64'(cyc), 64'(e.cyc));
                check_eq(k == K_SET ? "set_time" : "attempt", d, e.data);
                $display("event kind=%0d cycle=%0d data=0x%0h", k, cyc, d);
            end
        end
    end

    initial begin
        int p;

        // Reset state
        step(3);
        check_eq("rst_req_en", 64'(req_en), 64'(0));
        check_eq("rst_set_valid", 64'(set_valid), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_fail", 64'(fail), 64'(0));
        check_eq("rst_attempt", 64'(attempt), 64'(0));
        check_eq("rst_set_time", set_time, 64'(0));
        reset_n = 1'b1;
        step(2);

        // Press then successful fetch
        p = cyc;
        manual_btn = 1'b1;
        push(K_REQ, p + 1, 64'(0));
        step(1);
        check_eq("s1_busy_req", 64'(busy), 64'(1));
        step(1);
        manual_btn = 1'b0;
        step(3);
        check_eq("s1_busy_wait", 64'(busy), 64'(1));
        fetch_done = 1'b1;
        fetch_time = 32'h6700_1234;
        push(K_SET, cyc + 1, 64'h0000_0000_6700_1234);
        step(1);
        fetch_done = 1'b0;
        fetch_time = '0;
        step(1);
        check_eq("s1_busy_idle", 64'(busy), 64'(0));
        check_eq("s1_set_time_hold", set_time, 64'h0000_0000_6700_1234);
        step(5);
        check_eq("s1_sb_empty", 64'(sb.size()), 64'(0));

        // No fetch: three attempts 21 cycles apart, then fail
        p = cyc;
        manual_btn = 1'b1;
        push(K_REQ, p + 1, 64'(0));
        push(K_REQ, p + 22, 64'(1));
        push(K_REQ, p + 43, 64'(2));
        push(K_FAIL, p + 64, 64'(2));
        step(2);
        manual_btn = 1'b0;
        step(28);
        check_eq("s2_attempt_mid", 64'(attempt), 64'(1));
        check_eq("s2_busy_mid", 64'(busy), 64'(1));
        step(36);
        check_eq("s2_busy_after_fail", 64'(busy), 64'(0));
        check_eq("s2_set_time_kept", set_time, 64'h0000_0000_6700_1234);
        step(3);
        check_eq("s2_sb_empty", 64'(sb.size()), 64'(0));

        // Auto-resync: fifth tick starts a request; ticks during WAIT queue another
        for (int i = 0; i < 5; i++) begin
            tick_1hz = 1'b1;
            if (i == 4) push(K_REQ, cyc + 1, 64'(0));
            step(1);
            tick_1hz = 1'b0;
            step(1);
        end
        step(1);
        for (int i = 0; i < 5; i++) begin
            tick_1hz = 1'b1;
            step(1);
            tick_1hz = 1'b0;
            step(1);
        end
        fetch_done = 1'b1;
        fetch_time = 32'h0ABC_DEF0;
        push(K_SET, cyc + 1, 64'h0000_0000_0ABC_DEF0);
        push(K_REQ, cyc + 3, 64'(0));
        step(1);
        fetch_done = 1'b0;
        step(4);
        fetch_done = 1'b1;
        fetch_time = 32'hFFFF_FFFF;
        push(K_SET, cyc + 1, 64'h0000_0000_FFFF_FFFF);
        step(1);
        fetch_done = 1'b0;
        step(4);
        check_eq("s3_sb_empty", 64'(sb.size()), 64'(0));

        // Second press aborts; later fetch_done is ignored
        p = cyc;
        manual_btn = 1'b1;
        push(K_REQ, p + 1, 64'(0));
        step(2);
        manual_btn = 1'b0;
        step(3);
        manual_btn = 1'b1;
        step(1);
        check_eq("s4_busy_abort", 64'(busy), 64'(0));
        step(1);
        manual_btn = 1'b0;
        step(1);
        fetch_done = 1'b1;
        fetch_time = 32'h1111_2222;
        step(1);
        fetch_done = 1'b0;
        check_eq("s4_set_time_unchanged", set_time, 64'h0000_0000_FFFF_FFFF);
        step(25);
        check_eq("s4_sb_empty", 64'(sb.size()), 64'(0));
        check_eq("s4_busy_end", 64'(busy), 64'(0));

        // fetch_done on the timeout cycle wins over the retry
        p = cyc;
        manual_btn = 1'b1;
        push(K_REQ, p + 1, 64'(0));
        step(2);
        manual_btn = 1'b0;
        step(19);
        fetch_done = 1'b1;
        fetch_time = 32'h5555_AAAA;
        push(K_SET, cyc + 1, 64'h0000_0000_5555_AAAA);
        step(1);
        fetch_done = 1'b0;
        step(30);
        check_eq("s5_sb_empty", 64'(sb.size()), 64'(0));

        // Reset during WAIT clears everything immediately
        p = cyc;
        manual_btn = 1'b1;
        push(K_REQ, p + 1, 64'(0));
        step(2);
        manual_btn = 1'b0;
        step(3);
        reset_n = 1'b0;
        #1;
        check_eq("s6_rst_busy", 64'(busy), 64'(0));
        check_eq("s6_rst_req_en", 64'(req_en), 64'(0));
        check_eq("s6_rst_set_time", set_time, 64'(0));
        check_eq("s6_rst_attempt", 64'(attempt), 64'(0));
        step(1);
        reset_n = 1'b1;
        step(30);
        check_eq("s6_no_req_after_rst", 64'(sb.size()), 64'(0));
        manual_btn = 1'b1;
        push(K_REQ, cyc + 1, 64'(0));
        step(2);
        manual_btn = 1'b0;
        step(2);
        fetch_done = 1'b1;
        fetch_time = 32'h0000_0042;
        push(K_SET, cyc + 1, 64'h0000_0000_0000_0042);
        step(1);
        fetch_done = 1'b0;
        step(4);
        check_eq("s6_sb_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
